// File: rtl/uart_dbg_pkg.sv
// Shared definitions for the debugger UART transmitter and receiver.
package uart_dbg_pkg;

  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  function automatic int unsigned clks_per_bit(input int unsigned freq, input int unsigned baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_dbg_fifo.sv
// Synchronous fall-through FIFO; rdata_o shows the head whenever empty_o is low.
module uart_dbg_fifo #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned WIDTH      = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push_i,
  input  logic [WIDTH-1:0]              wdata_i,
  input  logic                          pop_i,
  output logic [WIDTH-1:0]              rdata_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = AW + 1;

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("uart_dbg_fifo: FIFO_DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d;
  logic [AW-1:0]    rptr_q, rptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_ok, pop_ok;

  assign full_o  = (level_q == LW'(FIFO_DEPTH));
  assign empty_o = (level_q == '0);
  assign level_o = level_q;
  assign rdata_o = mem_q[rptr_q];

  // Push acceptance looks only at the registered occupancy, never at a same-cycle pop.
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (push_ok) wptr_d = wptr_q + AW'(1);
    if (pop_ok)  rptr_d = rptr_q + AW'(1);
    if (push_ok && !pop_ok)      level_d = level_q + LW'(1);
    else if (!push_ok && pop_ok) level_d = level_q - LW'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/uart_dbg_tx.sv
// Debug-response UART transmitter: byte FIFO plus 8N1 serialiser.
// Define UART_DBG_TX_PARITY_EN to insert an even parity bit (8E1).
module uart_dbg_tx
  import uart_dbg_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 25_000_000,
  parameter int unsigned BAUD_RATE   = 115_200,
  parameter int unsigned FIFO_DEPTH  = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [7:0]                    tx_data_i,
  input  logic                          tx_valid_i,
  output logic                          tx_ready_o,
  output logic                          uart_tx_o,
  output logic                          uart_busy_o,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o
);

  localparam int unsigned CPB      = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int unsigned CW       = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int unsigned LW       = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW       = $clog2(UART_DATA_BITS);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CPB - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(UART_DATA_BITS - 1);

  if (CPB < 2) begin : g_cpb_chk
    $error("uart_dbg_tx: CLK_FREQ_HZ / BAUD_RATE must be at least 2");
  end

  tx_state_e                 state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [BW-1:0]             bit_q, bit_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic                      tx_q, tx_d;
  logic                      busy_q, busy_d;
`ifdef UART_DBG_TX_PARITY_EN
  logic                      par_q, par_d;
`endif

  logic                      pop;
  logic                      push_ok;
  logic                      bit_end;
  logic                      fifo_full, fifo_empty;
  logic [7:0]                fifo_rdata;
  logic [LW-1:0]             fifo_level;
  logic [LW-1:0]             level_next;

  uart_dbg_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .WIDTH      (8)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (tx_valid_i),
    .wdata_i (tx_data_i),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .level_o (fifo_level)
  );

  assign tx_ready_o   = !fifo_full;
  assign push_ok      = tx_valid_i && !fifo_full;
  assign uart_tx_o    = tx_q;
  assign uart_busy_o  = busy_q;
  assign fifo_level_o = fifo_level;
  assign bit_end      = (cnt_q == CNT_MAX);
  assign level_next   = fifo_level + LW'(push_ok) - LW'(pop);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
`ifdef UART_DBG_TX_PARITY_EN
    par_d   = par_q;
`endif

    if (state_q != IDLE) cnt_d = bit_end ? '0 : cnt_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == BIT_LAST) begin
            bit_d = '0;
`ifdef UART_DBG_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end
      end
`ifdef UART_DBG_TX_PARITY_EN
      PARITY: begin
        if (bit_end) state_d = STOP;
      end
`endif
      STOP: begin
        // Chain straight into the next start bit so queued bytes leave with no idle gap.
        if (bit_end) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (pop) begin
      shift_d = fifo_rdata;
      cnt_d   = '0;
`ifdef UART_DBG_TX_PARITY_EN
      par_d   = ^fifo_rdata;
`endif
    end
  end

  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_q[0];
`ifdef UART_DBG_TX_PARITY_EN
      PARITY: tx_d = par_q;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  assign busy_d = (state_d != IDLE) || (level_next != '0);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
`ifdef UART_DBG_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
`ifdef UART_DBG_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_dbg_tx.sv
// Self-checking bench for uart_dbg_tx: line decoder plus expected-byte scoreboard.
module tb_uart_dbg_tx;

  localparam int CPB = 4;
`ifdef UART_DBG_TX_PARITY_EN
  localparam int FB = 11;
  localparam bit PAR_EN = 1'b1;
`else
  localparam int FB = 10;
  localparam bit PAR_EN = 1'b0;
`endif

  logic       clk;
  logic       rst_n;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       uart_tx;
  logic       uart_busy;
  logic [3:0] fifo_level;

  uart_dbg_tx #(
    .CLK_FREQ_HZ (4),
    .BAUD_RATE   (1),
    .FIFO_DEPTH  (8)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .tx_data_i    (tx_data),
    .tx_valid_i   (tx_valid),
    .tx_ready_o   (tx_ready),
    .uart_tx_o    (uart_tx),
    .uart_busy_o  (uart_busy),
    .fifo_level_o (fifo_level)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int frames   = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic ones_parity(input logic [7:0] d);
    int n = 0;
    for (int i = 0; i < 8; i++) if (d[i]) n++;
    return logic'(n % 2);
  endfunction

  // Line decoder: one frame is FB bit-times of CPB cycles, every cycle of a bit must agree.
  bit          rx_active = 1'b0;
  bit          glitch;
  int          rx_cyc;
  logic [FB-1:0] rx_bits;

  task automatic finish_frame();
    logic [7:0] d;
    d = rx_bits[8:1];
    check("bit_stable", 32'(glitch), 32'd0);
    check("start_bit", 32'(rx_bits[0]), 32'd0);
    check("stop_bit", 32'(rx_bits[FB-1]), 32'd1);
`ifdef UART_DBG_TX_PARITY_EN
    check("parity_bit", 32'(rx_bits[9]), 32'(ones_parity(d)));
`endif
    if (exp_q.size() == 0) check("unexpected_frame", 32'(d), 32'hFFFF_FFFF);
    else check("rx_data", 32'(d), 32'(exp_q.pop_front()));
  endtask

  initial forever begin
    @(negedge clk);
    if (rst_n !== 1'b1) begin
      rx_active = 1'b0;
      continue;
    end
    if (!rx_active && uart_tx === 1'b0) begin
      rx_active = 1'b1;
      rx_cyc    = 0;
      glitch    = 1'b0;
      start_q.push_back(cyc);
    end
    if (rx_active) begin
      if (rx_cyc % CPB == 0) rx_bits[rx_cyc / CPB] = uart_tx;
      else if (uart_tx !== rx_bits[rx_cyc / CPB]) glitch = 1'b1;
      rx_cyc++;
      if (rx_cyc == FB * CPB) begin
        rx_active = 1'b0;
        frames++;
        finish_frame();
      end
    end
  end

  task automatic wait_idle(input int limit, input string name);
    bit done = 1'b0;
    for (int g = 0; g < limit; g++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !uart_busy && !rx_active) begin
        done = 1'b1;
        break;
      end
    end
    check(name, 32'(done), 32'd1);
  endtask

  // Single byte into an idle transmitter, with exact cycle-level timing checks.
  task automatic send_single(input logic [7:0] d, input logic p);
    logic [10:0] fbits;
    int bad = 0;
    fbits = {1'b1, p, d, 1'b0};
    if (!PAR_EN) fbits[9] = 1'b1;
    @(negedge clk);
    check("ready_idle", 32'(tx_ready), 32'd1);
    tx_data  = d;
    tx_valid = 1'b1;
    exp_q.push_back(d);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'($urandom);
    check("level_after_push", 32'(fifo_level), 32'd1);
    for (int k = 1; k <= FB * CPB + 2; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check("line_pre_start", 32'(uart_tx), 32'd1);
        check("level_after_pop", 32'(fifo_level), 32'd0);
      end
      if (k == 2) check("start_latency", 32'(uart_tx), 32'd0);
      if (k >= 2 && k < FB * CPB + 2 && uart_tx !== fbits[(k - 2) / CPB]) bad++;
      if (k == FB * CPB) check("busy_last_cycle", 32'(uart_busy), 32'd1);
      if (k == FB * CPB + 1) check("busy_end", 32'(uart_busy), 32'd0);
      if (k == FB * CPB + 2) check("line_idle_after", 32'(uart_tx), 32'd1);
    end
    check("frame_bits", 32'(bad), 32'd0);
  endtask

  typedef struct {
    logic [7:0] data;
    logic       par;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int base_frames;
    int base_starts;
    int accepted;
    int bad;
    bit saw_full;

    tbl[0] = '{data: 8'hA5, par: 1'b0};
    tbl[1] = '{data: 8'h07, par: 1'b1};
    tbl[2] = '{data: 8'h03, par: 1'b0};
    tbl[3] = '{data: 8'h00, par: 1'b0};
    tbl[4] = '{data: 8'hFF, par: 1'b0};
    tbl[5] = '{data: 8'h80, par: 1'b1};

    rst_n    = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_line", 32'(uart_tx), 32'd1);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(uart_busy), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 6; i++) send_single(tbl[i].data, tbl[i].par);
    wait_idle(200, "single_drain");

    // Back-to-back pushes: frames must abut with no idle gap.
    base_starts = start_q.size();
    base_frames = frames;
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'h00; exp_q.push_back(8'h00);
    @(negedge clk);
    check("b2b_level0", 32'(fifo_level), 32'd1);
    tx_data = 8'hFF; exp_q.push_back(8'hFF);
    @(negedge clk);
    check("b2b_level1", 32'(fifo_level), 32'd1);
    tx_data = 8'h55; exp_q.push_back(8'h55);
    @(negedge clk);
    tx_valid = 1'b0;
    check("b2b_level2", 32'(fifo_level), 32'd2);
    wait_idle(3 * FB * CPB + 50, "b2b_drain");
    check("b2b_frames", 32'(frames - base_frames), 32'd3);
    if (start_q.size() >= base_starts + 3) begin
      check("b2b_gap01", 32'(start_q[base_starts + 1] - start_q[base_starts]), 32'(FB * CPB));
      check("b2b_gap12", 32'(start_q[base_starts + 2] - start_q[base_starts + 1]), 32'(FB * CPB));
    end else begin
      check("b2b_starts", 32'(start_q.size() - base_starts), 32'd3);
    end
    check("b2b_level_end", 32'(fifo_level), 32'd0);

    // Backpressure: valid held high until nine bytes are accepted.
    base_frames = frames;
    accepted = 0;
    for (int g = 0; g < 200; g++) begin
      @(negedge clk);
      if (accepted == 9) break;
      tx_valid = 1'b1;
      tx_data  = 8'hC0 + 8'(accepted);
      if (tx_ready) begin
        exp_q.push_back(tx_data);
        accepted++;
      end
    end
    check("bp_accepted", 32'(accepted), 32'd9);
    check("bp_full_level", 32'(fifo_level), 32'd8);
    check("bp_ready_low", 32'(tx_ready), 32'd0);
    // Offer a tenth byte while full; it must be refused, including on the pop edge.
    tx_data  = 8'hEE;
    saw_full = 1'b0;
    bad      = 0;
    for (int g = 0; g < 200; g++) begin
      if (tx_ready) break;
      saw_full = 1'b1;
      if (fifo_level != 4'd8) bad++;
      @(negedge clk);
    end
    tx_valid = 1'b0;
    check("bp_saw_full", 32'(saw_full), 32'd1);
    check("bp_level_while_full", 32'(bad), 32'd0);
    check("bp_ready_back", 32'(tx_ready), 32'd1);
    check("bp_level_after_pop", 32'(fifo_level), 32'd7);
    wait_idle(9 * FB * CPB + 100, "bp_drain");
    check("bp_frames", 32'(frames - base_frames), 32'd9);

    // Reset during data bit 3 of 0x3C with four more bytes queued.
    @(negedge clk);
    tx_valid = 1'b1; tx_data = 8'h3C; exp_q.push_back(8'h3C);
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      tx_data = 8'h90 + 8'(k);
      exp_q.push_back(tx_data);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    repeat (14) @(negedge clk);
    check("mid_level", 32'(fifo_level), 32'd4);
    check("mid_busy", 32'(uart_busy), 32'd1);
    check("mid_bit3", 32'(uart_tx), 32'd1);
    base_frames = frames;
    rst_n = 1'b0;
    #1;
    check("arst_line", 32'(uart_tx), 32'd1);
    check("arst_level", 32'(fifo_level), 32'd0);
    check("arst_busy", 32'(uart_busy), 32'd0);
    check("arst_ready", 32'(tx_ready), 32'd1);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int g = 0; g < 100; g++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || uart_busy !== 1'b0) bad++;
    end
    check("post_rst_idle", 32'(bad), 32'd0);
    check("post_rst_frames", 32'(frames - base_frames), 32'd0);

    // Random traffic with random valid gaps, decoded and scoreboarded.
    base_frames = frames;
    accepted = 0;
    for (int g = 0; g < 20000; g++) begin
      @(negedge clk);
      if (accepted == 256) break;
      tx_valid = ($urandom_range(3) != 0);
      tx_data  = 8'($urandom);
      if (tx_valid && tx_ready) begin
        exp_q.push_back(tx_data);
        accepted++;
      end
    end
    tx_valid = 1'b0;
    check("rand_accepted", 32'(accepted), 32'd256);
    wait_idle(256 * FB * CPB + 500, "rand_drain");
    check("rand_frames", 32'(frames - base_frames), 32'd256);
    check("rand_level_end", 32'(fifo_level), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
